// File: rtl/stall_mem_resp_pkg.sv
// Shared types and constants for the multi-cycle MEM-stage data memory responder.
package stall_mem_resp_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // A request is serviceable only as a single word-aligned read or write.
  function automatic logic is_legal(input logic rd, input logic wr, input logic addr_lsb);
    return (rd ^ wr) && !addr_lsb;
  endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port word array: synchronous write, registered read, contents never reset.
module mem_array_sp
  import stall_mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // NOTE: the array has no reset so it maps onto block RAM; reset only aborts
  // in-flight accesses in the controller, it never clears stored data.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/stall_mem_resp.sv
// MEM-stage data memory that holds the pipeline for LATENCY cycles per access,
// then pulses Done with read data (or err for a malformed request).
module stall_mem_resp
  import stall_mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048,
  parameter int LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [IDX_W-1:0]  lat_idx;
  logic [DATA_W-1:0] lat_data;
  logic              lat_wr;
  logic              err_n;
  logic              accept;
  logic              legal;
  logic              req;
  logic              do_access;
  logic [DATA_W-1:0] rd_data;

  assign req   = Rd | Wr;
  assign legal = is_legal(Rd, Wr, Addr[0]);

  // Upper address bits beyond the array are intentionally dropped (wrap).
  logic unused_addr;
  if (IDX_W + 1 < ADDR_W) begin : g_unused_addr
    assign unused_addr = ^Addr[ADDR_W-1:IDX_W+1];
  end else begin : g_no_unused_addr
    assign unused_addr = 1'b0;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    Stall   = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (legal) begin
          accept  = 1'b1;
          Stall   = 1'b1;
          cnt_n   = CNT_LOAD;
          state_n = BUSY;
        end else begin
          err_n   = req;
          state_n = IDLE;
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (cnt != 4'd0) cnt_n = cnt - 4'd1;
        else             state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      err      <= 1'b0;
      lat_idx  <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err   <= err_n;
      if (accept) begin
        lat_idx  <= Addr[IDX_W:1];
        lat_data <= DataIn;
        lat_wr   <= Wr;
      end
    end
  end

  // The access fires on the last BUSY edge; a coincident reset cancels it.
  assign do_access = (state == BUSY) && (cnt == 4'd0) && !rst;

  mem_array_sp #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk   (clk),
    .we    (do_access && lat_wr),
    .re    (do_access && !lat_wr),
    .idx   (lat_idx),
    .wdata (lat_data),
    .rdata (rd_data)
  );

  assign Done    = (state == DONE);
  assign DataOut = (Done && !lat_wr) ? rd_data : '0;

endmodule

// File: tb/tb_stall_mem_resp.sv
// Scoreboard bench: driver predicts Stall/Done/err from a cycle-level model of
// the memory protocol; a negedge monitor pops and compares.
module tb_stall_mem_resp;

  localparam int L     = 4;
  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Rd, Wr, Done, Stall, err;

  always #5 clk = ~clk;

  stall_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .err(err)
  );

  typedef struct { int cyc; bit is_err; logic [15:0] data; } ev_t;
  typedef struct { int cyc; bit val; } st_t;

  ev_t ev_q[$];
  st_t st_q[$];

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  bit  mon_on = 1'b0;

  // Reference model state
  logic [15:0] ref_mem [DEPTH];
  int          busy_until = -1;
  bit          pend_v = 1'b0;
  int          pend_cyc;
  int          pend_idx;
  logic [15:0] pend_data;

  logic [10:0] pool [8] = '{11'h008, 11'h010, 11'h018, 11'h000,
                            11'h001, 11'h3FF, 11'h7FF, 11'h100};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs and record what the DUT must show in that cycle.
  task automatic step(input bit rd, input bit wr, input logic [15:0] a,
                      input logic [15:0] d, input bit r);
    int  c;
    bit  free, legal;
    int  idx;
    ev_t keep[$];
    c     = cyc;
    Rd    = rd;
    Wr    = wr;
    Addr  = a;
    DataIn = d;
    rst   = r;
    free  = c > busy_until;
    legal = (rd ^ wr) && !a[0];
    st_q.push_back('{c, free ? legal : 1'b1});
    if (r) begin
      foreach (ev_q[i]) if (ev_q[i].cyc <= c) keep.push_back(ev_q[i]);
      ev_q       = keep;
      busy_until = -1;
      pend_v     = 1'b0;
    end else begin
      if (free && legal) begin
        idx        = int'(a[11:1]);
        busy_until = c + L;
        ev_q.push_back('{c + L + 1, 1'b0, rd ? ref_mem[idx] : 16'h0000});
        if (wr) begin
          pend_v    = 1'b1;
          pend_cyc  = c + L;
          pend_idx  = idx;
          pend_data = d;
        end
      end else if (free && (rd | wr)) begin
        ev_q.push_back('{c + 1, 1'b1, 16'h0000});
      end
      if (pend_v && pend_cyc == c) begin
        ref_mem[pend_idx] = pend_data;
        pend_v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  // Present a request for one cycle, then wait so the next call lands in DONE.
  task automatic do_req(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
    step(rd, wr, a, d, 1'b0);
    idle(L);
  endtask

  ev_t e;
  st_t s;
  always @(negedge clk) begin
    if (mon_on) begin
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        check($sformatf("stall@%0d", s.cyc), {31'b0, Stall}, {31'b0, s.val});
      end
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        e = ev_q.pop_front();
        if (e.is_err) begin
          check("err_pulse", {31'b0, err}, 32'd1);
          check("done_during_err", {31'b0, Done}, 32'd0);
        end else begin
          check("done_pulse", {31'b0, Done}, 32'd1);
          check("err_during_done", {31'b0, err}, 32'd0);
          check("dataout", {16'b0, DataOut}, {16'b0, e.data});
        end
      end else begin
        check("no_done", {31'b0, Done}, 32'd0);
        check("no_err", {31'b0, err}, 32'd0);
        check("dataout_zero", {16'b0, DataOut}, 32'd0);
        if (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
          e = ev_q.pop_front();
          total++;
          bad++;
          $display("FAIL missed_event: expected %s at cycle %0d, got none",
                   e.is_err ? "err" : "Done", e.cyc);
        end
      end
    end
  end

  initial begin
    int sel;
    logic [15:0] a;
    rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;
    repeat (3) @(posedge clk);
    #1;
    mon_on = 1'b1;

    // Reset state held for 3 idle cycles
    idle(3);

    // Seed every address the bench will read
    foreach (pool[i]) do_req(1'b0, 1'b1, {4'($urandom), pool[i], 1'b0}, 16'($urandom));

    // Write then read back
    do_req(1'b0, 1'b1, 16'h0010, 16'h1234);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(2);

    // Back-to-back: read issued in the write's DONE cycle
    do_req(1'b0, 1'b1, 16'h0020, 16'hBEEF);
    do_req(1'b1, 1'b0, 16'h0020, 16'h0000);
    idle(1);

    // Illegal requests
    step(1'b1, 1'b1, 16'h0004, 16'hAAAA, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 16'h0003, 16'hDEAD, 1'b0);
    idle(2);
    do_req(1'b1, 1'b0, 16'h0002, 16'h0000);
    idle(1);

    // Upper address bits wrap onto the same word
    do_req(1'b0, 1'b1, 16'h1000, 16'h5A5A);
    do_req(1'b1, 1'b0, 16'h0000, 16'h0000);
    idle(1);

    // Reset in the second BUSY cycle aborts the write
    step(1'b0, 1'b1, 16'h0030, 16'hFFFF, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    idle(2);
    do_req(1'b1, 1'b0, 16'h0030, 16'h0000);
    idle(1);

    // Randomized traffic, with junk driven while busy and rare resets
    for (int n = 0; n < 600; n++) begin
      a = {4'($urandom), pool[$urandom_range(0, 7)], 1'b0};
      if ($urandom_range(0, 99) == 0) begin
        step(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'b1);
      end else if (cyc > busy_until) begin
        sel = $urandom_range(0, 9);
        case (sel)
          0, 1, 2, 3: step(1'b1, 1'b0, a, 16'($urandom), 1'b0);
          4, 5, 6:    step(1'b0, 1'b1, a, 16'($urandom), 1'b0);
          7:          step(1'b1, 1'b1, a, 16'($urandom), 1'b0);
          8:          step(1'b1, 1'b0, a | 16'h0001, 16'($urandom), 1'b0);
          default:    step(1'b0, 1'b0, a, 16'($urandom), 1'b0);
        endcase
      end else begin
        step(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'b0);
      end
    end

    idle(L + 2);
    @(negedge clk);
    #1;
    mon_on = 1'b0;
    check("events_drained", ev_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
